// File: rtl/exec_resolve_if.sv
// Data-memory request/acknowledge bundle between the execute/resolve stage and data memory.
interface exec_resolve_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, output dmem_addr, input dmem_ack, input dmem_rdata);
  modport slave  (input dmem_req, input dmem_addr, output dmem_ack, output dmem_rdata);
endinterface

// File: rtl/exec_resolve.sv
// Execute/resolve stage: ALU writeback, branch/jump redirect with one-cycle flush, blocking loads.
// Optional taken-redirect counter enabled by defining EXEC_BRANCH_CNT_EN.
module exec_resolve (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           pc_in,
  input  logic [4:0]            rd_in,
  input  logic [31:0]           rs1_val,
  input  logic [31:0]           rs2_val,
  input  logic [31:0]           imm,
  input  logic [11:0]           code,
  input  logic                  is_load,
  input  logic                  is_branch,
  output logic [31:0]           pc_branch,
  output logic                  origin_pc,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  exec_resolve_if.master        dmem,
  output logic                  stall,
  output logic [15:0]           branch_count
);

  typedef enum logic [1:0] {RUN, LOAD_WAIT, FLUSH} state_t;

  state_t      state;
  logic [4:0]  load_rd;
  logic        taken;
  logic        jump;
  logic        redirect_fire;
  logic [31:0] sum;
  logic        unused_code;

  assign unused_code   = ^code[10:3];
  assign sum           = rs1_val + imm;
  assign jump          = code[11] | (is_branch & taken);
  assign redirect_fire = (state == RUN) & in_valid & jump;

  always_comb begin
    taken = 1'b0;
    case (code[2:0])
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc_branch      <= '0;
      origin_pc      <= 1'b0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      dmem.dmem_req  <= 1'b0;
      dmem.dmem_addr <= '0;
      stall          <= 1'b0;
      load_rd        <= '0;
    end else begin
      rf_we     <= 1'b0;
      origin_pc <= 1'b0;
      case (state)
        RUN: begin
          if (in_valid) begin
            // jumps and branches outrank loads when decode flags overlap
            if (jump) begin
              origin_pc <= 1'b1;
              pc_branch <= pc_in + imm;
              state     <= FLUSH;
            end else if (is_branch) begin
              state <= RUN;
            end else if (is_load) begin
              dmem.dmem_req  <= 1'b1;
              dmem.dmem_addr <= sum;
              stall          <= 1'b1;
              load_rd        <= rd_in;
              state          <= LOAD_WAIT;
            end else begin
              rf_we    <= (rd_in != 5'd0);
              rf_waddr <= rd_in;
              rf_wdata <= sum;
            end
          end
        end
        LOAD_WAIT: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            stall         <= 1'b0;
            rf_we         <= (load_rd != 5'd0);
            rf_waddr      <= load_rd;
            rf_wdata      <= dmem.dmem_rdata;
            state         <= RUN;
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef EXEC_BRANCH_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)              cnt_q <= '0;
    else if (redirect_fire) cnt_q <= cnt_q + 16'd1;
  end

  assign branch_count = cnt_q;
`else
  logic unused_fire;

  assign unused_fire  = redirect_fire;
  assign branch_count = '0;
`endif

endmodule

// File: tb/tb_exec_resolve.sv
// Randomized and directed bench for exec_resolve against a transaction-level reference model.
module tb_exec_resolve;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [4:0]  rd_in;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [11:0] code;
  logic        is_load;
  logic        is_branch;
  logic [31:0] pc_branch;
  logic        origin_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic [15:0] branch_count;

  exec_resolve_if dbus ();

  exec_resolve dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .rd_in(rd_in),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .code(code),
    .is_load(is_load), .is_branch(is_branch), .pc_branch(pc_branch),
    .origin_pc(origin_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dmem(dbus), .stall(stall), .branch_count(branch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: pending-load and pending-flush flags plus expected outputs
  bit          m_busy, m_flush;
  logic [4:0]  m_lrd;
  logic [15:0] m_cnt;
  logic        e_org, e_we, e_req, e_stall;
  logic [31:0] e_pcb, e_wdata, e_addr;
  logic [4:0]  e_waddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_cycle();
    e_we  = 1'b0;
    e_org = 1'b0;
    if (reset) begin
      m_busy = 0; m_flush = 0; e_req = 0; e_stall = 0; m_cnt = '0;
    end else if (m_busy) begin
      if (dbus.dmem_ack) begin
        m_busy = 0; e_req = 0; e_stall = 0;
        e_we = (m_lrd != 0); e_waddr = m_lrd; e_wdata = dbus.dmem_rdata;
      end
    end else if (m_flush) begin
      m_flush = 0;
    end else if (in_valid) begin
      if (code[11] || (is_branch && br_taken(code[2:0], rs1_val, rs2_val))) begin
        e_org = 1; e_pcb = pc_in + imm; m_flush = 1;
        m_cnt = m_cnt + 16'd1;
      end else if (is_branch) begin
        e_org = 0;
      end else if (is_load) begin
        m_busy = 1; e_req = 1; e_stall = 1; e_addr = rs1_val + imm; m_lrd = rd_in;
      end else begin
        e_we = (rd_in != 0); e_waddr = rd_in; e_wdata = rs1_val + imm;
      end
    end
    @(posedge clk);
    #1;
    chk("origin_pc", origin_pc, e_org);
    chk("rf_we", rf_we, e_we);
    chk("dmem_req", dbus.dmem_req, e_req);
    chk("stall", stall, e_stall);
`ifdef EXEC_BRANCH_CNT_EN
    chk("branch_count", branch_count, m_cnt);
`else
    chk("branch_count", branch_count, 0);
`endif
    if (e_org)  chk("pc_branch", pc_branch, e_pcb);
    if (e_we)   begin chk("rf_waddr", rf_waddr, e_waddr); chk("rf_wdata", rf_wdata, e_wdata); end
    if (e_req)  chk("dmem_addr", dbus.dmem_addr, e_addr);
  endtask

  task automatic idle();
    reset = 0; in_valid = 0; pc_in = 0; rd_in = 0; rs1_val = 0; rs2_val = 0;
    imm = 0; code = 0; is_load = 0; is_branch = 0;
    dbus.dmem_ack = 0; dbus.dmem_rdata = 0;
  endtask

  task automatic op(input logic ld, input logic br, input logic [11:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd, input logic [31:0] pc);
    in_valid = 1; is_load = ld; is_branch = br; code = c;
    rs1_val = a; rs2_val = b; imm = im; rd_in = rd; pc_in = pc;
  endtask

  int stall_cycles;

  initial begin
    idle();
    reset = 1;
    op(1'b0, 1'b0, 12'h000, 32'd5, 32'd0, 32'd3, 5'd7, 32'd0);
    do_cycle();
    do_cycle();
    chk("rst_pc_branch", pc_branch, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_dmem_addr", dbus.dmem_addr, 0);
    chk("rst_branch_count", branch_count, 0);
    idle();

    // plain op
    op(1'b0, 1'b0, 12'h000, 32'd5, 32'd0, 32'd3, 5'd7, 32'd0);
    do_cycle();
    chk("plain_we", rf_we, 1);
    chk("plain_waddr", rf_waddr, 7);
    chk("plain_wdata", rf_wdata, 8);
    idle();
    do_cycle();
    chk("plain_we_one_cycle", rf_we, 0);

    // BEQ taken, next valid instruction flushed
    op(1'b0, 1'b1, 12'h000, 32'd9, 32'd9, 32'h10, 5'd1, 32'h40);
    do_cycle();
    chk("beq_origin", origin_pc, 1);
    chk("beq_target", pc_branch, 32'h50);
    op(1'b0, 1'b0, 12'h000, 32'd1, 32'd0, 32'd1, 5'd4, 32'h44);
    do_cycle();
    chk("flush_no_we", rf_we, 0);
    chk("flush_origin_drop", origin_pc, 0);

    // signed vs unsigned compare
    op(1'b0, 1'b1, 12'h004, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd1, 32'h100);
    do_cycle();
    chk("blt_taken", origin_pc, 1);
    idle();
    do_cycle();
    op(1'b0, 1'b1, 12'h006, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd1, 32'h100);
    do_cycle();
    chk("bltu_not_taken", origin_pc, 0);
    chk("bltu_no_we", rf_we, 0);

    // load with three stall cycles
    op(1'b1, 1'b0, 12'h000, 32'h100, 32'd0, 32'd4, 5'd3, 32'h200);
    do_cycle();
    chk("load_addr", dbus.dmem_addr, 32'h104);
    stall_cycles = (stall === 1'b1) ? 1 : 0;
    op(1'b0, 1'b0, 12'h000, 32'd1, 32'd0, 32'd1, 5'd9, 32'h0);
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      if (stall === 1'b1) stall_cycles++;
      chk("load_addr_hold", dbus.dmem_addr, 32'h104);
    end
    idle();
    dbus.dmem_ack = 1; dbus.dmem_rdata = 32'hDEAD_BEEF;
    do_cycle();
    chk("load_stall_cycles", stall_cycles, 3);
    chk("load_we", rf_we, 1);
    chk("load_waddr", rf_waddr, 3);
    chk("load_wdata", rf_wdata, 32'hDEAD_BEEF);
    idle();

    // reset during LOAD_WAIT, then a plain op proves RUN
    op(1'b1, 1'b0, 12'h000, 32'h10, 32'd0, 32'd0, 5'd5, 32'h0);
    do_cycle();
    idle();
    reset = 1;
    dbus.dmem_ack = 1;
    do_cycle();
    chk("rst_lw_req", dbus.dmem_req, 0);
    chk("rst_lw_we", rf_we, 0);
    idle();
    op(1'b0, 1'b0, 12'h000, 32'd2, 32'd0, 32'd2, 5'd6, 32'h0);
    do_cycle();
    chk("rst_lw_run", rf_we, 1);
    idle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 60) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      is_load   = $urandom_range(0, 2) == 0;
      is_branch = $urandom_range(0, 2) == 0;
      code      = 12'($urandom);
      code[11]  = ($urandom_range(0, 5) == 0);
      rs1_val   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 6)) - 3);
      rs2_val   = ($urandom_range(0, 2) == 0) ? rs1_val : 32'($signed($urandom_range(0, 6)) - 3);
      imm       = $urandom;
      rd_in     = 5'($urandom);
      pc_in     = $urandom;
      dbus.dmem_ack   = ($urandom_range(0, 2) == 0);
      dbus.dmem_rdata = $urandom;
      do_cycle();
    end
    idle();

`ifdef EXEC_BRANCH_CNT_EN
    reset = 1;
    do_cycle();
    idle();
    op(1'b0, 1'b0, 12'h800, 32'd0, 32'd0, 32'd8, 5'd0, 32'h0);
    for (int i = 0; i < 65537; i++) begin
      do_cycle();
      do_cycle();
    end
    chk("cnt_wrap", branch_count, 1);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_resolve.md
EXEC_RESOLVE -- requirements
Module: exec_resolve

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock; all state updates on posedge.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have in_valid  input  1  fetch-stage instruction valid (fetch write-enable).
REQ-004 SHALL have pc_in  input  32  PC of the incoming instruction.
REQ-005 SHALL have rd_in  input  5  destination register index.
REQ-006 SHALL have rs1_val, rs2_val  input  32 each  register operand values.
REQ-007 SHALL have imm  input  32  sign-extended immediate.
REQ-008 SHALL have code  input  12  op code; code[2:0] = funct3, code[11] = unconditional jump.
REQ-009 SHALL have is_load, is_branch  input  1 each  decoded class flags.
REQ-010 SHALL have pc_branch  output  32  redirect target to fetch.
REQ-011 SHALL have origin_pc  output  1  redirect strobe to fetch.
REQ-012 SHALL have rf_we  output  1, rf_waddr  output  5, rf_wdata  output  32  register-file write port.
REQ-013 SHALL have dmem_req  output  1, dmem_addr  output  32, dmem_ack  input  1, dmem_rdata  input  32  data-memory handshake.
REQ-014 SHALL have stall  output  1  hold request to fetch.
REQ-015 SHALL have branch_count  output  16  taken-redirect counter.

Function
REQ-016 SHALL implement FSM states RUN, LOAD_WAIT, FLUSH; all outputs registered.
REQ-017 SHALL, in RUN with in_valid and no is_load/is_branch/code[11], assert rf_we for 1 cycle next posedge with rf_wdata = rs1_val + imm (mod 2^32), rf_waddr = rd_in.
REQ-018 SHALL evaluate branches in RUN with in_valid and is_branch: funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 never taken.
REQ-019 SHALL, on taken branch or code[11]=1, assert origin_pc for exactly 1 cycle after the posedge with pc_branch = pc_in + imm, then enter FLUSH; origin_pc SHALL be stable before the following negedge.
REQ-020 SHALL, in FLUSH, discard one cycle of input regardless of in_valid (no writeback, no dmem_req), then return to RUN.
REQ-021 SHALL, on not-taken branch, stay in RUN with no writeback and origin_pc = 0.
REQ-022 SHALL, in RUN with in_valid and is_load, assert dmem_req with dmem_addr = rs1_val + imm, assert stall, enter LOAD_WAIT.
REQ-023 SHALL hold dmem_req, dmem_addr, stall constant in LOAD_WAIT until dmem_ack sampled high.
REQ-024 SHALL, on dmem_ack in LOAD_WAIT, deassert dmem_req/stall next cycle, write dmem_rdata to the latched rd for 1 cycle, return to RUN.
REQ-025 SHALL ignore dmem_ack outside LOAD_WAIT.
REQ-026 SHALL suppress rf_we whenever the destination index is 0.
REQ-027 SHALL give is_branch priority over is_load when both are set.
REQ-028 SHALL ignore in_valid while in LOAD_WAIT.

Reset
REQ-029 SHALL, on reset, enter RUN and drive pc_branch, origin_pc, rf_we, rf_waddr, rf_wdata, dmem_req, dmem_addr, stall, branch_count to 0.
REQ-030 SHALL, on reset during LOAD_WAIT, drop dmem_req next cycle and perform no writeback.

Configuration
REQ-031 SHALL, with EXEC_BRANCH_CNT_EN defined, increment branch_count by 1 per origin_pc pulse, wrapping 0xFFFF -> 0x0000.
REQ-032 SHALL, without EXEC_BRANCH_CNT_EN, tie branch_count to 0 and instantiate no counter.

Verification
REQ-033 SHALL cover: rs1_val=5, imm=3, rd_in=7, plain op -> rf_we=1, rf_waddr=7, rf_wdata=8 one cycle later.
REQ-034 SHALL cover: BEQ rs1=rs2=9, pc_in=0x40, imm=0x10 -> origin_pc=1 one cycle, pc_branch=0x50; next in_valid instruction produces no write.
REQ-035 SHALL cover: BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken.
REQ-036 SHALL cover: load rs1=0x100, imm=4, rd=3, dmem_ack after 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x104, stall held 3 cycles, then rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
REQ-037 SHALL cover: reset asserted during LOAD_WAIT -> dmem_req=0, rf_we=0, state RUN.
REQ-038 SHALL cover: with EXEC_BRANCH_CNT_EN, 65537 taken branches -> branch_count=1.
